ysyx22041405_mem_responder: RTL and testbench

- Memory-side responder for the load/store and fetch request channel driven by the pipeline's LSU/IFU.
- Accepts one request at a time on a valid/ready channel and services it against an internal word-organised RAM with byte strobes.
- After a fixed, parameterised delay it returns read data, or a write acknowledge, on a valid/ready response channel.
- Sits outside the core as the simulation memory, and is the counterpart for a future stallable LSU.

---
 rtl/ysyx22041405_mem_pkg.sv | 19 +
 rtl/ysyx22041405_sram_bank.sv | 27 ++
 rtl/ysyx22041405_mem_responder.sv | 139 +++++++++++++
 tb/tb_ysyx22041405_mem_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx22041405_mem_pkg.sv
// Shared types and constants for the simulation memory responder.
// Request bundle width is a macro so core pipeline defines can reuse it.
`ifndef YSYX22041405_REQ_W
`define YSYX22041405_REQ_W(aw, w) (1 + (aw) + (w) + (w) / 8)
`endif

package ysyx22041405_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] BASE_ADDR_DFLT = 32'h8000_0000;

  localparam int REQ_W = `YSYX22041405_REQ_W(32, 32);

endpackage

// File: rtl/ysyx22041405_sram_bank.sv
// Word-organised RAM, byte-strobed synchronous write, combinational read.
// Contents are never reset.
module ysyx22041405_sram_bank #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (wstrb[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ysyx22041405_mem_responder.sv
// Single-outstanding memory responder: valid/ready request in,
// fixed-latency valid/ready response out, backed by one SRAM bank.
module ysyx22041405_mem_responder
  import ysyx22041405_mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(BASE_ADDR_DFLT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [WIDTH/8-1:0]    req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB  = WIDTH / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int CW  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(LATENCY);
  localparam logic [ADDR_WIDTH:0] SPAN =
    (ADDR_WIDTH+1)'(NB) << DEPTH_LOG2;

  state_e                state;
  logic [CW-1:0]         cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0]      cap_wdata;
  logic [NB-1:0]         cap_wstrb;

  logic                  idle;
  logic                  accept;
  logic                  commit;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [WIDTH-1:0]      c_wdata;
  logic [NB-1:0]         c_wstrb;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  in_rng;
  logic                  ram_we;
  logic [WIDTH-1:0]      ram_rdata;
  logic                  unused_bits;

  assign idle   = (state == IDLE);
  assign accept = req_valid & req_ready;

  // With zero latency the commit happens on the accept edge itself,
  // so the live request fields feed the RAM instead of the capture.
  assign c_we    = idle ? req_we    : cap_we;
  assign c_addr  = idle ? req_addr  : cap_addr;
  assign c_wdata = idle ? req_wdata : cap_wdata;
  assign c_wstrb = idle ? req_wstrb : cap_wstrb;

  assign commit = (idle && accept && LATENCY == 0)
                || (state == WAIT && cnt == CW'(1));

  assign offset      = c_addr - BASE_ADDR;
  assign idx_full    = offset >> OFF;
  assign unused_bits = ^idx_full;
  assign in_rng      = (c_addr >= BASE_ADDR)
                     && ({1'b0, offset} < SPAN);
  assign ram_we      = commit & c_we & in_rng & ~rst;

  ysyx22041405_sram_bank #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx_full[DEPTH_LOG2-1:0]),
    .wdata (c_wdata),
    .wstrb (c_wstrb),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
            cnt       <= LAT;
            req_ready <= 1'b0;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ~in_rng;
        rsp_rdata <= (!c_we && in_rng) ? ram_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx22041405_mem_responder.sv
// Scoreboard bench: a LATENCY=2 responder and a LATENCY=0 responder.
module tb_ysyx22041405_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic [3:0]  b_req_wstrb = '0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b1;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  ysyx22041405_mem_responder #(.LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  ysyx22041405_mem_responder #(.LATENCY(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_wstrb (b_req_wstrb),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  // Response monitors: a handshake happens at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected rdata=%h err=%b", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          errors++;
          $display("FAIL sb_a_rsp got rdata=%h err=%b want rdata=%h err=%b",
                   rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst && b_rsp_valid === 1'b1 && b_rsp_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected rdata=%h err=%b",
                 b_rsp_rdata, b_rsp_err);
      end else begin
        e = sb_b.pop_front();
        if (b_rsp_rdata !== e.rdata || b_rsp_err !== e.err) begin
          errors++;
          $display("FAIL sb_b_rsp got rdata=%h err=%b want rdata=%h err=%b",
                   b_rsp_rdata, b_rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  // Drive one request on the LATENCY=2 port, push its expectation,
  // and return the edges from accept to rsp_valid (-1 on timeout).
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err,
                       output int lat);
    int n;
    exp_t e;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) lat = -1;
    n = 0;
    while (rsp_valid === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata);
    end
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_err got %b want 0", rsp_err);
    end
    checks++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat0 got ready=%b valid=%b want 1 0",
               b_req_ready, b_rsp_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL wr_latency got %0d want 2", lat);
    end
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL rd_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_partial_strobe();
    int lat;
    issue(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, lat);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, lat);
    issue(1'b1, 32'h8000_0014, 32'h5555_5555, 4'h0, 32'h0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL noop_write_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    issue(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, lat);
    issue(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, lat);
    issue(1'b1, 32'h8000_4000, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, lat);
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, lat);
    issue(1'b1, 32'h8000_3FFC, 32'h1234_5678, 4'hF, 32'h0, 1'b0, lat);
    issue(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 32'h1234_5678, 1'b0, lat);
    issue(1'b0, 32'h8000_4000, 32'h0, 4'h0, 32'h0, 1'b1, lat);
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_we    = 1'b0;
    req_addr  = 32'h8000_0010;
    req_valid = 1'b1;
    e.rdata = 32'hDE22_BE44;
    e.err   = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    req_addr  = 32'h8000_0000;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22_BE44) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b rdata=%h want 1 %h",
                 i, rsp_valid, rsp_rdata, 32'hDE22_BE44);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_req_ready cyc=%0d got %b want 0", i, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e.rdata = 32'hCAFE_F00D;
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs got ready=%b valid=%b want 1 0",
               req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got ready=%b want 0", req_ready);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL bp_second_latency got %0d want 2", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    issue(1'b1, 32'h8000_0020, 32'h0102_0304, 4'hF, 32'h0, 1'b0, lat);
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got ready=%b valid=%b want 1 0",
               req_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_rsp cyc=%0d got %b want 0", i, rsp_valid);
      end
    end
    issue(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0102_0304, 1'b0, lat);
  endtask

  task automatic test_latency0();
    logic [31:0] ad [2];
    logic        we [2];
    logic [31:0] ex [2];
    exp_t e;
    ad[0] = 32'h8000_0100; we[0] = 1'b1; ex[0] = 32'h0;
    ad[1] = 32'h8000_0100; we[1] = 1'b0; ex[1] = 32'hAABB_CCDD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_req_we    = we[i];
      b_req_addr  = ad[i];
      b_req_wdata = 32'hAABB_CCDD;
      b_req_wstrb = 4'hF;
      b_req_valid = 1'b1;
      e.rdata = ex[i];
      e.err   = 1'b0;
      sb_b.push_back(e);
      @(negedge clk);
      b_req_valid = 1'b0;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL lat0_rsp txn=%0d got valid=%b ready=%b want 1 0",
                 i, b_rsp_valid, b_req_ready);
      end
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL lat0_done txn=%0d got valid=%b ready=%b want 0 1",
                 i, b_rsp_valid, b_req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_reset_abort();
    test_latency0();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d pending want 0/0",
               sb.size(), sb_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
